// File: rtl/video_types_pkg.sv
// -----------------------------------------------------------------------------
// video_types
//   Shared types and constants for the graphics block.
//   - lcd_mode_t      : STAT mode encoding (0 HBlank, 1 VBlank, 2 OAM, 3 XFER)
//   - LCD_* timing    : default dot/line timing of the LCD sequencer
//   - STAT_IE_*       : bit positions inside the STAT interrupt-enable field
//   - lcd_mode_legal  : true when from_mode -> to_mode is a legal sequencer step
// -----------------------------------------------------------------------------
package video_types;

  typedef enum logic [1:0] {
    LCD_HBLANK = 2'd0,
    LCD_VBLANK = 2'd1,
    LCD_OAM    = 2'd2,
    LCD_XFER   = 2'd3
  } lcd_mode_t;

  localparam int LCD_DOTS_PER_LINE = 456;
  localparam int LCD_OAM_DOTS      = 80;
  localparam int LCD_XFER_DOTS     = 172;
  localparam int LCD_VISIBLE_LINES = 144;
  localparam int LCD_TOTAL_LINES   = 154;

  localparam int STAT_IE_HBLANK = 0;
  localparam int STAT_IE_VBLANK = 1;
  localparam int STAT_IE_OAM    = 2;
  localparam int STAT_IE_LYC    = 3;

  // Only the natural scan order is legal: OAM -> XFER -> HBlank -> OAM/VBlank,
  // and VBlank -> OAM when the frame wraps.
  function automatic logic lcd_mode_legal(input lcd_mode_t from_mode,
                                          input lcd_mode_t to_mode);
    logic ok;
    ok = 1'b0;
    case (from_mode)
      LCD_OAM:    ok = (to_mode == LCD_XFER);
      LCD_XFER:   ok = (to_mode == LCD_HBLANK);
      LCD_HBLANK: ok = (to_mode == LCD_OAM) || (to_mode == LCD_VBLANK);
      LCD_VBLANK: ok = (to_mode == LCD_OAM);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lcd_stat_irq.sv
// -----------------------------------------------------------------------------
// lcd_stat_irq
//   Combines the four STAT sources with their enables into one STAT line,
//   registers it, and emits a single-cycle request on each 0->1 edge.
//   The inputs are the *next* mode/coincidence values of the sequencer, so the
//   registered STAT line and the request line up with the registered mode.
// Ports:
//   clk, reset         : clock, asynchronous active-low reset
//   clear              : synchronous clear of STAT line history and request
//   mode_next          : mode the sequencer will show after this edge
//   coincidence_next   : LY==LYC value the sequencer will show after this edge
//   stat_ie[3:0]       : source enables (HBlank, VBlank, OAM, LYC)
//   stat_irq           : 1-cycle interrupt request
// -----------------------------------------------------------------------------
module lcd_stat_irq
  import video_types::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic [1:0] mode_next,
  input  logic       coincidence_next,
  input  logic [3:0] stat_ie,
  output logic       stat_irq
);

  logic [3:0] src;
  logic [3:0] gated;
  logic       stat_line_next;
  logic       stat_line_reg;
  logic       stat_irq_reg;

  assign src[STAT_IE_HBLANK] = (mode_next == LCD_HBLANK);
  assign src[STAT_IE_VBLANK] = (mode_next == LCD_VBLANK);
  assign src[STAT_IE_OAM]    = (mode_next == LCD_OAM);
  assign src[STAT_IE_LYC]    = coincidence_next;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_gate
    assign gated[gi] = src[gi] & stat_ie[gi];
  end

  assign stat_line_next = |gated;

  // Back-to-back sources keep the line high, so they merge into one request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_line_reg <= 1'b0;
      stat_irq_reg  <= 1'b0;
    end else if (clear) begin
      stat_line_reg <= 1'b0;
      stat_irq_reg  <= 1'b0;
    end else begin
      stat_line_reg <= stat_line_next;
      stat_irq_reg  <= stat_line_next & ~stat_line_reg;
    end
  end

  assign stat_irq = stat_irq_reg;

endmodule

// File: rtl/lcd_timing_ctrl.sv
// -----------------------------------------------------------------------------
// lcd_timing_ctrl
//   Dot-level LCD sequencer: dot and line counters, STAT mode, LY==LYC flag,
//   per-line drawline strobe, VBlank/STAT requests and CPU VRAM/OAM gating.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   lcd_enable     : LCDC.LCDEnable; low holds the sequencer at line 0, HBlank
//   lyc[7:0]       : LY compare value
//   stat_ie[3:0]   : STAT source enables (HBlank, VBlank, OAM, LYC)
//   mode[1:0]      : current mode (0 HBlank, 1 VBlank, 2 OAM, 3 XFER)
//   ly[7:0]        : current line
//   coincidence    : registered ly == lyc
//   drawline       : 1-cycle strobe on the first XFER cycle of visible lines
//   vblank_irq     : 1-cycle request on the first cycle of VBlank
//   stat_irq       : 1-cycle request on a rising STAT line
//   frame_done     : high throughout VBlank
//   cpu_vram_ok    : low during XFER
//   cpu_oam_ok     : low during OAM and XFER
// -----------------------------------------------------------------------------
module lcd_timing_ctrl
  import video_types::*;
#(
  parameter int DOTS_PER_LINE = LCD_DOTS_PER_LINE,
  parameter int OAM_DOTS      = LCD_OAM_DOTS,
  parameter int XFER_DOTS     = LCD_XFER_DOTS,
  parameter int VISIBLE_LINES = LCD_VISIBLE_LINES,
  parameter int TOTAL_LINES   = LCD_TOTAL_LINES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_enable,
  input  logic [7:0] lyc,
  input  logic [3:0] stat_ie,
  output logic [1:0] mode,
  output logic [7:0] ly,
  output logic       coincidence,
  output logic       drawline,
  output logic       vblank_irq,
  output logic       stat_irq,
  output logic       frame_done,
  output logic       cpu_vram_ok,
  output logic       cpu_oam_ok
);

  if (OAM_DOTS + XFER_DOTS >= DOTS_PER_LINE) begin : g_bad_line_timing
    $error("lcd_timing_ctrl: OAM_DOTS + XFER_DOTS must be below DOTS_PER_LINE");
  end
  if (DOTS_PER_LINE > 512 || TOTAL_LINES > 256 || VISIBLE_LINES >= TOTAL_LINES) begin : g_bad_frame_timing
    $error("lcd_timing_ctrl: timing does not fit the 9-bit dot / 8-bit line counters");
  end

  localparam logic [8:0] DOT_LAST  = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] OAM_END   = 9'(OAM_DOTS);
  localparam logic [8:0] XFER_END  = 9'(OAM_DOTS + XFER_DOTS);
  localparam logic [7:0] LINE_LAST = 8'(TOTAL_LINES - 1);
  localparam logic [7:0] VIS_LINES = 8'(VISIBLE_LINES);

  // The counters hold the position being decoded at the next edge; every
  // output register is loaded from that position, so outputs show the
  // position the counter held one edge earlier.
  logic [8:0] dot_cnt_reg, dot_cnt_next;
  logic [7:0] line_cnt_reg, line_cnt_next;
  lcd_mode_t  mode_reg, mode_next;
  logic [7:0] ly_reg, ly_next;
  logic       coincidence_reg, coincidence_next;
  logic       drawline_reg, drawline_next;
  logic       vblank_irq_reg, vblank_irq_next;
  logic       frame_done_reg;
  logic       cpu_vram_ok_reg;
  logic       cpu_oam_ok_reg;
  logic       stat_clear;

  always_comb begin
    dot_cnt_next  = dot_cnt_reg + 9'd1;
    line_cnt_next = line_cnt_reg;
    if (!lcd_enable) begin
      // Disabling discards any partially counted line.
      dot_cnt_next  = 9'd0;
      line_cnt_next = 8'd0;
    end else if (dot_cnt_reg == DOT_LAST) begin
      dot_cnt_next  = 9'd0;
      line_cnt_next = (line_cnt_reg == LINE_LAST) ? 8'd0 : line_cnt_reg + 8'd1;
    end
  end

  always_comb begin
    mode_next = LCD_HBLANK;
    if (lcd_enable) begin
      if (line_cnt_reg >= VIS_LINES)  mode_next = LCD_VBLANK;
      else if (dot_cnt_reg < OAM_END)  mode_next = LCD_OAM;
      else if (dot_cnt_reg < XFER_END) mode_next = LCD_XFER;
      else                             mode_next = LCD_HBLANK;
    end
  end

  // While disabled LY reads 0 and the compare keeps running against it.
  assign ly_next          = lcd_enable ? line_cnt_reg : 8'd0;
  assign coincidence_next = (ly_next == lyc);
  assign drawline_next    = lcd_enable && (line_cnt_reg < VIS_LINES) && (dot_cnt_reg == OAM_END);
  assign vblank_irq_next  = lcd_enable && (line_cnt_reg == VIS_LINES) && (dot_cnt_reg == 9'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dot_cnt_reg     <= 9'd0;
      line_cnt_reg    <= 8'd0;
      mode_reg        <= LCD_HBLANK;
      ly_reg          <= 8'd0;
      coincidence_reg <= 1'b0;
      drawline_reg    <= 1'b0;
      vblank_irq_reg  <= 1'b0;
      frame_done_reg  <= 1'b0;
      cpu_vram_ok_reg <= 1'b1;
      cpu_oam_ok_reg  <= 1'b1;
    end else begin
      dot_cnt_reg     <= dot_cnt_next;
      line_cnt_reg    <= line_cnt_next;
      mode_reg        <= mode_next;
      ly_reg          <= ly_next;
      coincidence_reg <= coincidence_next;
      drawline_reg    <= drawline_next;
      vblank_irq_reg  <= vblank_irq_next;
      frame_done_reg  <= (mode_next == LCD_VBLANK);
      cpu_vram_ok_reg <= (mode_next != LCD_XFER);
      cpu_oam_ok_reg  <= (mode_next != LCD_XFER) && (mode_next != LCD_OAM);
    end
  end

  // Forced HBlank on disable is not a scan step, so only enabled steps are checked.
  always_ff @(posedge clk) begin
    if (reset && lcd_enable && (mode_next != mode_reg)) begin
      assert (lcd_mode_legal(mode_reg, mode_next));
    end
  end

  assign stat_clear = !lcd_enable;

  lcd_stat_irq u_stat_irq (
    .clk              (clk),
    .reset            (reset),
    .clear            (stat_clear),
    .mode_next        (mode_next),
    .coincidence_next (coincidence_next),
    .stat_ie          (stat_ie),
    .stat_irq         (stat_irq)
  );

  assign mode        = mode_reg;
  assign ly          = ly_reg;
  assign coincidence = coincidence_reg;
  assign drawline    = drawline_reg;
  assign vblank_irq  = vblank_irq_reg;
  assign frame_done  = frame_done_reg;
  assign cpu_vram_ok = cpu_vram_ok_reg;
  assign cpu_oam_ok  = cpu_oam_ok_reg;

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lcd_timing_ctrl
//   Directed bench for lcd_timing_ctrl. Cycle index c = 0 is the first cycle
//   after the first enabled clock edge (ly 0, dot 0, mode OAM).
// -----------------------------------------------------------------------------
module tb_lcd_timing_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       lcd_enable;
  logic [7:0] lyc;
  logic [3:0] stat_ie;
  logic [1:0] mode;
  logic [7:0] ly;
  logic       coincidence, drawline, vblank_irq, stat_irq, frame_done;
  logic       cpu_vram_ok, cpu_oam_ok;

  always #5 clk = ~clk;

  lcd_timing_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .lcd_enable  (lcd_enable),
    .lyc         (lyc),
    .stat_ie     (stat_ie),
    .mode        (mode),
    .ly          (ly),
    .coincidence (coincidence),
    .drawline    (drawline),
    .vblank_irq  (vblank_irq),
    .stat_irq    (stat_irq),
    .frame_done  (frame_done),
    .cpu_vram_ok (cpu_vram_ok),
    .cpu_oam_ok  (cpu_oam_ok)
  );

  localparam logic [1:0] M_HBL = 2'd0;
  localparam logic [1:0] M_VBL = 2'd1;
  localparam logic [1:0] M_OAM = 2'd2;
  localparam logic [1:0] M_XFR = 2'd3;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    int         cyc;
    logic [1:0] mode;
    logic [7:0] ly;
    logic       dl, vb, st, fd, co, vram, oam;
  } vec_t;

  vec_t vtab[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int cyc, input logic [1:0] m, input logic [7:0] l,
                     input logic dl, input logic vb, input logic st, input logic fd,
                     input logic co, input logic vram, input logic oam);
    vec_t v;
    v.cyc = cyc; v.mode = m; v.ly = l; v.dl = dl; v.vb = vb; v.st = st;
    v.fd = fd; v.co = co; v.vram = vram; v.oam = oam;
    vtab.push_back(v);
  endtask

  task automatic apply_vec(input vec_t v);
    chk($sformatf("c%0d mode", v.cyc),        32'(mode),        32'(v.mode));
    chk($sformatf("c%0d ly", v.cyc),          32'(ly),          32'(v.ly));
    chk($sformatf("c%0d drawline", v.cyc),    32'(drawline),    32'(v.dl));
    chk($sformatf("c%0d vblank_irq", v.cyc),  32'(vblank_irq),  32'(v.vb));
    chk($sformatf("c%0d stat_irq", v.cyc),    32'(stat_irq),    32'(v.st));
    chk($sformatf("c%0d frame_done", v.cyc),  32'(frame_done),  32'(v.fd));
    chk($sformatf("c%0d coincidence", v.cyc), 32'(coincidence), 32'(v.co));
    chk($sformatf("c%0d cpu_vram_ok", v.cyc), 32'(cpu_vram_ok), 32'(v.vram));
    chk($sformatf("c%0d cpu_oam_ok", v.cyc),  32'(cpu_oam_ok),  32'(v.oam));
    $display("vec c=%0d ly=%0d mode=%0d dl=%0b vb=%0b st=%0b fd=%0b co=%0b vram=%0b oam=%0b",
             v.cyc, ly, mode, drawline, vblank_irq, stat_irq, frame_done, coincidence,
             cpu_vram_ok, cpu_oam_ok);
  endtask

  initial begin
    int vi;
    int dl_cnt, vb_cnt, fd_cnt, st_cnt, co_cnt, st_cyc, bad_cnt;
    int m_cnt[4];

    // Frame table: lyc=10, stat_ie=0011 (HBlank+VBlank).
    //    cyc    mode   ly   dl vb st fd co vr oa
    add(0,     M_OAM, 0,   0, 0, 0, 0, 0, 1, 0);
    add(79,    M_OAM, 0,   0, 0, 0, 0, 0, 1, 0);
    add(80,    M_XFR, 0,   1, 0, 0, 0, 0, 0, 0);
    add(81,    M_XFR, 0,   0, 0, 0, 0, 0, 0, 0);
    add(251,   M_XFR, 0,   0, 0, 0, 0, 0, 0, 0);
    add(252,   M_HBL, 0,   0, 0, 1, 0, 0, 1, 1);
    add(253,   M_HBL, 0,   0, 0, 0, 0, 0, 1, 1);
    add(455,   M_HBL, 0,   0, 0, 0, 0, 0, 1, 1);
    add(456,   M_OAM, 1,   0, 0, 0, 0, 0, 1, 0);
    add(4560,  M_OAM, 10,  0, 0, 0, 0, 1, 1, 0);
    add(5015,  M_HBL, 10,  0, 0, 0, 0, 1, 1, 1);
    add(5016,  M_OAM, 11,  0, 0, 0, 0, 0, 1, 0);
    add(65460, M_HBL, 143, 0, 0, 1, 0, 0, 1, 1);
    add(65663, M_HBL, 143, 0, 0, 0, 0, 0, 1, 1);
    add(65664, M_VBL, 144, 0, 1, 0, 1, 0, 1, 1);
    add(65665, M_VBL, 144, 0, 0, 0, 1, 0, 1, 1);
    add(70223, M_VBL, 153, 0, 0, 0, 1, 0, 1, 1);
    add(70224, M_OAM, 0,   0, 0, 0, 0, 0, 1, 0);
    add(70304, M_XFR, 0,   1, 0, 0, 0, 0, 0, 0);

    // ---- reset values ----
    reset = 1'b0; lcd_enable = 1'b0; lyc = 8'd0; stat_ie = 4'd0;
    repeat (3) step();
    chk("rst mode", 32'(mode), 32'(M_HBL));
    chk("rst ly", 32'(ly), 32'd0);
    chk("rst coincidence", 32'(coincidence), 32'd0);
    chk("rst strobes", 32'({drawline, vblank_irq, stat_irq}), 32'd0);
    chk("rst frame_done", 32'(frame_done), 32'd0);
    chk("rst cpu_ok", 32'({cpu_vram_ok, cpu_oam_ok}), 32'b11);
    $display("reset: mode=%0d ly=%0d vram=%0b oam=%0b", mode, ly, cpu_vram_ok, cpu_oam_ok);

    // ---- disabled: compare keeps running on ly=0, lyc change one clk later ----
    reset = 1'b1;
    step();
    chk("dis coin lyc0", 32'(coincidence), 32'd1);
    lyc = 8'd10;
    chk("dis coin before edge", 32'(coincidence), 32'd1);
    step();
    chk("dis coin lyc10", 32'(coincidence), 32'd0);
    $display("lyc 0->10 while disabled: coincidence=%0b", coincidence);

    // ---- full frame ----
    stat_ie = 4'b0011;
    lcd_enable = 1'b1;
    step();
    vi = 0; dl_cnt = 0; vb_cnt = 0; fd_cnt = 0; st_cnt = 0; co_cnt = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    for (int c = 0; c <= 70304; c++) begin
      if (vi < vtab.size() && vtab[vi].cyc == c) begin
        apply_vec(vtab[vi]);
        vi++;
      end
      if (c < 70224) begin
        dl_cnt += int'(drawline);
        vb_cnt += int'(vblank_irq);
        fd_cnt += int'(frame_done);
        st_cnt += int'(stat_irq);
        co_cnt += int'(coincidence);
      end
      if (c < 456) m_cnt[mode]++;
      step();
    end
    chk("line0 OAM dots", 32'(m_cnt[M_OAM]), 32'd80);
    chk("line0 XFER dots", 32'(m_cnt[M_XFR]), 32'd172);
    chk("line0 HBlank dots", 32'(m_cnt[M_HBL]), 32'd204);
    chk("line0 VBlank dots", 32'(m_cnt[M_VBL]), 32'd0);
    chk("frame drawlines", 32'(dl_cnt), 32'd144);
    chk("frame vblank_irqs", 32'(vb_cnt), 32'd1);
    chk("frame frame_done clks", 32'(fd_cnt), 32'd4560);
    chk("frame stat_irqs ie0011", 32'(st_cnt), 32'd144);
    chk("frame coincidence clks", 32'(co_cnt), 32'd456);
    $display("frame: drawline=%0d vblank=%0d frame_done=%0d stat=%0d coin=%0d",
             dl_cnt, vb_cnt, fd_cnt, st_cnt, co_cnt);

    // ---- LYC interrupt, then disable mid-XFER at ly 12 dot 200 ----
    lcd_enable = 1'b0;
    step();
    lyc = 8'd10; stat_ie = 4'b1000;
    step();
    lcd_enable = 1'b1;
    step();
    st_cnt = 0; co_cnt = 0; st_cyc = -1;
    for (int c = 0; c < 5672; c++) begin
      if (stat_irq) begin
        st_cnt++;
        if (st_cyc < 0) st_cyc = c;
      end
      co_cnt += int'(coincidence);
      step();
    end
    chk("lyc stat_irq count", 32'(st_cnt), 32'd1);
    chk("lyc stat_irq cycle", 32'(st_cyc), 32'd4560);
    chk("lyc coincidence clks", 32'(co_cnt), 32'd456);
    chk("pre-disable mode", 32'(mode), 32'(M_XFR));
    chk("pre-disable ly", 32'(ly), 32'd12);
    $display("lyc=10: stat pulses=%0d at c=%0d, coincidence clks=%0d", st_cnt, st_cyc, co_cnt);
    lcd_enable = 1'b0;
    step();
    chk("disable ly", 32'(ly), 32'd0);
    chk("disable mode", 32'(mode), 32'(M_HBL));
    chk("disable cpu_ok", 32'({cpu_vram_ok, cpu_oam_ok}), 32'b11);
    chk("disable frame_done", 32'(frame_done), 32'd0);
    chk("disable strobes", 32'({drawline, vblank_irq, stat_irq}), 32'd0);
    $display("disable at ly12 dot200: ly=%0d mode=%0d vram=%0b oam=%0b", ly, mode, cpu_vram_ok, cpu_oam_ok);

    // ---- HBlank+OAM sources, re-enable timing ----
    stat_ie = 4'b0101; lyc = 8'd200;
    repeat (2) step();
    chk("disabled stat_irq", 32'(stat_irq), 32'd0);
    lcd_enable = 1'b1;
    step();
    st_cnt = 0; dl_cnt = 0;
    for (int c = 0; c <= 600; c++) begin
      if (c == 0) begin
        chk("reen c0 mode", 32'(mode), 32'(M_OAM));
        chk("reen c0 ly", 32'(ly), 32'd0);
        chk("reen c0 stat_irq", 32'(stat_irq), 32'd1);
      end
      if (c == 80)  chk("reen c80 drawline", 32'(drawline), 32'd1);
      if (c == 252) chk("reen c252 stat_irq", 32'(stat_irq), 32'd1);
      if (c == 456) chk("reen c456 merged stat", 32'(stat_irq), 32'd0);
      if (c < 456) dl_cnt += int'(drawline);
      st_cnt += int'(stat_irq);
      step();
    end
    chk("ie0101 stat count", 32'(st_cnt), 32'd2);
    chk("reen line0 drawlines", 32'(dl_cnt), 32'd1);
    $display("ie=0101: stat pulses=%0d, line0 drawlines=%0d", st_cnt, dl_cnt);

    // ---- asynchronous reset mid-XFER (now at ly1 dot145) ----
    chk("pre-reset mode", 32'(mode), 32'(M_XFR));
    #3;
    reset = 1'b0;
    #1;
    chk("async rst mode", 32'(mode), 32'(M_HBL));
    chk("async rst ly", 32'(ly), 32'd0);
    chk("async rst cpu_ok", 32'({cpu_vram_ok, cpu_oam_ok}), 32'b11);
    chk("async rst flags", 32'({coincidence, drawline, vblank_irq, stat_irq, frame_done}), 32'd0);
    $display("async reset mid-XFER: mode=%0d ly=%0d vram=%0b oam=%0b", mode, ly, cpu_vram_ok, cpu_oam_ok);
    lcd_enable = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    bad_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (drawline || vblank_irq || stat_irq || mode != M_HBL) bad_cnt++;
    end
    chk("post-reset idle activity", 32'(bad_cnt), 32'd0);
    lcd_enable = 1'b1;
    step();
    chk("restart c0 mode", 32'(mode), 32'(M_OAM));
    dl_cnt = 0;
    for (int c = 0; c < 80; c++) begin
      dl_cnt += int'(drawline);
      step();
    end
    chk("restart early drawline", 32'(dl_cnt), 32'd0);
    chk("restart c80 drawline", 32'(drawline), 32'd1);
    $display("restart after reset: drawline at c80=%0b", drawline);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/lcd_timing_ctrl.md
Name: lcd_timing_ctrl

Overview:
Dot-level sequencer for the graphics block. It owns the dot counter, the line counter (LY), the STAT mode and the LYC coincidence flag. It issues one `drawline` strobe per visible line to the line renderer, raises the VBlank and STAT interrupt requests, and gates CPU access to VRAM and OAM by mode. It sits between the system clock and the renderer/bus decoder, and replaces the free-running line divider.

Parameters:
DOTS_PER_LINE, 456, clocks per scanline
OAM_DOTS, 80, length of mode 2 (OAM search)
XFER_DOTS, 172, length of mode 3 (pixel transfer)
VISIBLE_LINES, 144, rendered lines per frame
TOTAL_LINES, 154, visible lines plus VBlank lines

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
lcd_enable  in  1  LCDC.LCDEnable
lyc  in  8  LY compare register value
stat_ie  in  4  STAT source enables: [0] HBlank, [1] VBlank, [2] OAM, [3] LYC
mode  out  2  LcdMode: 0 HBlank, 1 VBlank, 2 OAM, 3 XFER
ly  out  8  current line
coincidence  out  1  ly == lyc
drawline  out  1  1-cycle strobe, renderer renders line `ly`
vblank_irq  out  1  1-cycle interrupt request
stat_irq  out  1  1-cycle interrupt request
frame_done  out  1  level, high during VBlank
cpu_vram_ok  out  1  CPU may access VRAM
cpu_oam_ok  out  1  CPU may access OAM

Behaviour:
- Reset (reset=0, asynchronous): dot=0, ly=0, mode=HBlank, coincidence=0, all strobes 0, frame_done=0, cpu_vram_ok=1, cpu_oam_ok=1.
- Internal dot counter: 9 bits, increments each clk while lcd_enable=1.
  - Wraps to 0 at DOTS_PER_LINE-1; ly increments on that wrap.
  - ly wraps TOTAL_LINES-1 -> 0.
- Mode, all outputs registered:
  - If ly >= VISIBLE_LINES: VBlank.
  - Else if dot < OAM_DOTS: OAM.
  - Else if dot < OAM_DOTS+XFER_DOTS: XFER.
  - Else: HBlank.
- Mode state transitions: OAM -> XFER -> HBlank -> (OAM or VBlank); VBlank -> OAM at ly wrap. No other transitions are legal; add an assertion.
- drawline: pulses on the first clk of XFER, visible lines only, exactly once per visible line.
- vblank_irq: pulses on the first clk of ly=VISIBLE_LINES, dot 0.
- frame_done: 1 throughout VBlank.
- coincidence: registered compare, ly==lyc. A change on lyc is reflected one clk later.
- STAT line = (HBlank & ie[0]) | (VBlank & ie[1]) | (OAM & ie[2]) | (coincidence & ie[3]).
  - stat_irq pulses only on a 0->1 edge of the STAT line (STAT blocking).
  - Consecutive sources with no low gap produce a single pulse.
- CPU access:
  - cpu_oam_ok = 0 in OAM and XFER.
  - cpu_vram_ok = 0 in XFER.
  - Both are 1 otherwise.
- lcd_enable=0:
  - Synchronously force dot=0, ly=0, mode=HBlank, frame_done=0, both cpu_*_ok=1.
  - No strobes or IRQs; the STAT edge detector history is cleared.
  - coincidence keeps comparing (ly=0).
- lcd_enable 0->1: the first enabled clk is ly0 dot0 in mode OAM. The first drawline follows OAM_DOTS clks later.
- Disable mid-line or mid-frame takes effect on the next clk; a partially counted line is discarded.
- Parameter rule: require OAM_DOTS+XFER_DOTS < DOTS_PER_LINE, checked by an elaboration-time assertion.

Decomposition:
- Add to the shared `video_types` package:
  - `LcdMode` enum (2 bits, values above).
  - Localparams for the timing defaults.
  - STAT_IE bit index constants.
- One sub-module, `lcd_stat_irq`: combines sources and enables, registered OR, rising-edge detect, clear input driven by !lcd_enable.

Test Plan:
- Reset release, lcd_enable=1, run 456 clks -> mode sequence OAM for 80, XFER for 172, HBlank for 204; single drawline at dot 80; ly=1 at clk 456.
- Full frame of 70224 clks -> exactly 144 drawline pulses; one vblank_irq at ly=144 dot 0; frame_done high for 4560 clks; ly returns to 0.
- lyc=10, stat_ie=4'b1000 -> stat_irq pulses once when ly becomes 10; coincidence high for 456 clks, then low.
- stat_ie=4'b0101 (HBlank+OAM) -> one stat_irq per HBlank entry and one per OAM entry. With stat_ie=4'b0011 at the line-143 HBlank to VBlank boundary -> no extra pulse.
- lcd_enable dropped at ly=50, dot 200 -> next clk ly=0, mode=HBlank, cpu_vram_ok=cpu_oam_ok=1. Re-enable -> OAM at ly0, drawline after 80 clks.
- reset asserted mid-XFER (asynchronous, between clk edges) -> outputs at reset values immediately; no drawline or IRQ until the lcd_enable sequence restarts.
